syn_fifo_flex: RTL and testbench

- Parametrised single-clock FIFO; next generation of syn_fifo.
- Adds almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer pipeline stages in the same clock domain.
- Is drop-in compatible with syn_fifo flag naming (fifo_full_o, fifo_empty_o).

---
 rtl/syn_fifo_flex.sv | 124 ++++++++++++
 tb/tb_syn_fifo_flex.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_fifo_flex.sv
// Single-clock FIFO with level flags, occupancy count, sticky errors,
// synchronous flush and a selectable first-word-fall-through read port.
module syn_fifo_flex #(
  parameter int FIFO_ENTRIES  = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          clr_i,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          rd_en_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          rd_valid_o,
  output logic                          fifo_full_o,
  output logic                          fifo_empty_o,
  output logic                          fifo_afull_o,
  output logic                          fifo_aempty_o,
  output logic [$clog2(FIFO_ENTRIES):0] fifo_count_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  localparam int AW = $clog2(FIFO_ENTRIES);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_ENTRIES);
  localparam logic [PW-1:0] AF_CNT   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_CNT   = PW'(AEMPTY_THRESH);

  if (FIFO_ENTRIES < 2 ||
      (FIFO_ENTRIES & (FIFO_ENTRIES - 1)) != 0) begin : g_bad_depth
    $error("syn_fifo_flex: FIFO_ENTRIES must be a power of two >= 2");
  end

  if (AFULL_THRESH < 1 ||
      AFULL_THRESH > FIFO_ENTRIES) begin : g_bad_afull
    $error("syn_fifo_flex: AFULL_THRESH out of range");
  end

  if (AEMPTY_THRESH < 0 ||
      AEMPTY_THRESH > FIFO_ENTRIES - 1) begin : g_bad_aempty
    $error("syn_fifo_flex: AEMPTY_THRESH out of range");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_ENTRIES];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign wr_acc = wr_en_i & ~full;
  assign rd_acc = rd_en_i & ~empty;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc) count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      if (wr_en_i && full) ovf_q <= 1'b1;
      if (rd_en_i && empty) udf_q <= 1'b1;
    end
  end

  // Storage has no reset; occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !clr_i) mem[wr_ptr[AW-1:0]] <= wr_data_i;
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign rd_valid_o = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (clr_i) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr[AW-1:0]];
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
  end

  assign fifo_full_o   = full;
  assign fifo_empty_o  = empty;
  assign fifo_afull_o  = (count >= AF_CNT);
  assign fifo_aempty_o = (count <= AE_CNT);
  assign fifo_count_o  = count;
  assign overflow_o    = ovf_q;
  assign underflow_o   = udf_q;

endmodule

// File: tb/tb_syn_fifo_flex.sv
// Bench for syn_fifo_flex: standard and FWFT instances share stimulus,
// a queue model predicts contents and a negedge monitor checks read data.
module tb_syn_fifo_flex;

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;

  logic [7:0] rd_data, rd_data_f;
  logic       rd_valid, rd_valid_f;
  logic       full, full_f, empty, empty_f;
  logic       afull, afull_f, aempty, aempty_f;
  logic [4:0] count, count_f;
  logic       ovf, ovf_f, udf, udf_f;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq [$];
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  syn_fifo_flex #(.FWFT(0)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .clr_i(clr),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .fifo_full_o(full), .fifo_empty_o(empty),
    .fifo_afull_o(afull), .fifo_aempty_o(aempty),
    .fifo_count_o(count), .overflow_o(ovf), .underflow_o(udf)
  );

  syn_fifo_flex #(.FWFT(1)) dut_f (
    .clk_i(clk), .rstn_i(rstn_i), .clr_i(clr),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data_f), .rd_valid_o(rd_valid_f),
    .fifo_full_o(full_f), .fifo_empty_o(empty_f),
    .fifo_afull_o(afull_f), .fifo_aempty_o(aempty_f),
    .fifo_count_o(count_f), .overflow_o(ovf_f), .underflow_o(udf_f)
  );

  // Read-data scoreboard and FWFT head check
  always @(negedge clk) begin
    if (rstn_i) begin
      if (rd_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_data: rd_valid=1 with no pending read, data=%h",
                   rd_data);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (rd_data !== e) begin
            failures++;
            $display("FAIL sb_data: got %h expected %h", rd_data, e);
          end
        end
      end
      begin
        logic       ev;
        logic [7:0] ed;
        ev = (mq.size() != 0);
        ed = ev ? mq[0] : 8'h00;
        checks++;
        if (rd_valid_f !== ev || rd_data_f !== ed) begin
          failures++;
          $display("FAIL fwft_head: got v=%b d=%h expected v=%b d=%h",
                   rd_valid_f, rd_data_f, ev, ed);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input logic w, input logic [7:0] d,
                      input logic r, input logic c);
    logic fm, em;
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge clk);
    if (c) begin
      mq.delete();
      sb.delete();
    end else begin
      fm = (mq.size() == 16);
      em = (mq.size() == 0);
      if (r && !em) sb.push_back(mq.pop_front());
      if (w && !fm) mq.push_back(d);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd_data, rd_valid, full, empty, afull, aempty, count, ovf, udf}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_std: d=%h v=%b f=%b e=%b af=%b ae=%b c=%0d o=%b u=%b",
               rd_data, rd_valid, full, empty, afull, aempty, count, ovf, udf);
    end
    checks++;
    if ({rd_data_f, rd_valid_f, full_f, empty_f, afull_f, aempty_f,
         count_f, ovf_f, udf_f}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_fwft: d=%h v=%b f=%b e=%b c=%0d o=%b u=%b",
               rd_data_f, rd_valid_f, full_f, empty_f, count_f, ovf_f, udf_f);
    end
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (count !== 5'(i) || afull !== (i >= 12) || aempty !== (i <= 4)) begin
        failures++;
        $display("FAIL fill_%0d: count=%0d af=%b ae=%b expected %0d %b %b",
                 i, count, afull, aempty, i, (i >= 12), (i <= 4));
      end
    end
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: full=%b empty=%b expected 1 0", full, empty);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1 || count !== 5'd16 || udf !== 1'b0) begin
      failures++;
      $display("FAIL overflow: ovf=%b count=%0d udf=%b expected 1 16 0",
               ovf, count, udf);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1 || ovf !== 1'b1 || count !== 5'd0) begin
      failures++;
      $display("FAIL overflow_drain: empty=%b ovf=%b count=%0d expected 1 1 0",
               empty, ovf, count);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++)
        step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      checks++;
      if (full !== 1'b1 || count !== 5'd16) begin
        failures++;
        $display("FAIL wrap_fill_%0d: full=%b count=%0d expected 1 16",
                 r, full, count);
      end
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (empty !== 1'b1 || count !== 5'd0) begin
        failures++;
        $display("FAIL wrap_drain_%0d: empty=%b count=%0d expected 1 0",
                 r, empty, count);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0 || udf !== 1'b0) begin
      failures++;
      $display("FAIL clr_errors: ovf=%b udf=%b expected 0 0", ovf, udf);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      checks++;
      if (count !== 5'd8 || ovf !== 1'b0 || udf !== 1'b0) begin
        failures++;
        $display("FAIL simul_%0d: count=%0d ovf=%b udf=%b expected 8 0 0",
                 i, count, ovf, udf);
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL simul_drain: empty=%b expected 1", empty);
    end
  endtask

  task automatic test_underflow_flush();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (udf !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL underflow: udf=%b count=%0d valid=%b expected 1 0 0",
               udf, count, rd_valid);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || udf !== 1'b0 ||
        rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush: count=%0d empty=%b udf=%b valid=%b expected 0 1 0 0",
               count, empty, udf, rd_valid);
    end
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd0 || rd_valid !== 1'b1 || rd_data !== 8'h11) begin
      failures++;
      $display("FAIL post_flush: count=%0d valid=%b data=%h expected 0 1 11",
               count, rd_valid, rd_data);
    end
  endtask

  task automatic test_fwft();
    idle();
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    checks++;
    if (rd_valid_f !== 1'b1 || rd_data_f !== 8'h5C || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL fwft_show: vf=%b df=%h v=%b expected 1 5c 0",
               rd_valid_f, rd_data_f, rd_valid);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rd_valid_f !== 1'b0 || empty_f !== 1'b1) begin
      failures++;
      $display("FAIL fwft_pop: vf=%b ef=%b expected 0 1", rd_valid_f, empty_f);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    wr_en = 1'b1; wr_data = 8'hC3;
    #2;
    rstn_i = 1'b0;
    mq.delete();
    sb.delete();
    #1;
    checks++;
    if ({rd_data_f, rd_valid_f, full_f, empty_f, afull_f, aempty_f,
         count_f, ovf_f, udf_f}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fwft_reset: d=%h v=%b e=%b c=%0d o=%b u=%b",
               rd_data_f, rd_valid_f, empty_f, count_f, ovf_f, udf_f);
    end
    checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL std_midreset: v=%b c=%0d e=%b expected 0 0 1",
               rd_valid, count, empty);
    end
    wr_en = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b1, 8'h9A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h9A || count !== 5'd0) begin
      failures++;
      $display("FAIL after_reset: v=%b d=%h c=%0d expected 1 9a 0",
               rd_valid, rd_data, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_underflow_flush();
    test_fwft();
    idle();
    idle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d reads never returned, expected 0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
